// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding and default sizes for the divider
package divider_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, SHIFT, FIXUP, DONE} div_state_t;
  localparam int DIV_WIDTH = 16;
  localparam int DIV_ITERS = DIV_WIDTH;
endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division iteration
module divider_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o,
  output logic             q_o
);
  logic [WIDTH:0] trial;
  assign trial = {rem_i, dvd_i[WIDTH-1]} - {1'b0, divisor_i};
  assign q_o   = ~trial[WIDTH];
  assign rem_o = q_o ? trial[WIDTH-1:0] : {rem_i[WIDTH-2:0], dvd_i[WIDTH-1]};
  assign dvd_o = {dvd_i[WIDTH-2:0], 1'b0};
endmodule

// File: rtl/divider.sv
// divider: multi-cycle restoring divider; DIVIDER_SIGNED_EN adds signed_op for signed division
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_flag,
`ifdef DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(ITERS + 1);
  div_state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, dvd_q, dvd_d;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d;
  logic neg_a, neg_b;
  logic [WIDTH-1:0] a_mag, b_mag, step_rem, step_dvd;
  logic step_q;
`ifdef DIVIDER_SIGNED_EN
  logic sop_q, sop_d;
  assign neg_a = sop_q & a_q[WIDTH-1];
  assign neg_b = sop_q & b_q[WIDTH-1];
`else
  assign neg_a = 1'b0;
  assign neg_b = 1'b0;
`endif
  assign a_mag = neg_a ? -a_q : a_q;
  assign b_mag = neg_b ? -b_q : b_q;
  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q),
    .dvd_i(dvd_q),
    .divisor_i(b_mag),
    .rem_o(step_rem),
    .dvd_o(step_dvd),
    .q_o(step_q)
  );
  // next-state and datapath updates for each FSM state
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    rem_d = rem_q;
    dvd_d = dvd_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    dbz_d = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    sop_d = sop_q;
`endif
    case (state_q)
      IDLE: if (start_flag) begin
        state_d = CHECK;
        a_d = a;
        b_d = b;
        dbz_d = 1'b0;
`ifdef DIVIDER_SIGNED_EN
        sop_d = signed_op;
`endif
      end
      CHECK: if (b_q == '0) begin
        state_d = DONE;
        quo_d = '1;
        rmd_d = a_q;
        dbz_d = 1'b1;
      end else begin
        state_d = SHIFT;
        rem_d = '0;
        dvd_d = a_mag;
        cnt_d = CW'(ITERS);
      end
      SHIFT: begin
        rem_d = step_rem;
        dvd_d = step_dvd | {{(WIDTH-1){1'b0}}, step_q};
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? FIXUP : SHIFT;
      end
      FIXUP: begin
        state_d = DONE;
        quo_d = (neg_a ^ neg_b) ? -dvd_q : dvd_q;
        rmd_d = neg_a ? -rem_q : rem_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      dbz_q <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      sop_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      dbz_q <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
      sop_q <= sop_d;
`endif
    end
  end
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed scoreboard bench for divider
module tb_divider;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_flag = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] quotient, remainder;
  logic busy, done, div_by_zero;
`ifdef DIVIDER_SIGNED_EN
  logic signed_op = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic z;
    int at;
  } exp_t;
  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  divider dut (
    .clk(clk),
    .rst(rst),
    .start_flag(start_flag),
`ifdef DIVIDER_SIGNED_EN
    .signed_op(signed_op),
`endif
    .a(a),
    .b(b),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) chk("done_with_empty_queue", 0, 1);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        chk("latency_cycle", cyc, e.at);
      end
    end
  end

  task automatic go(input logic [W-1:0] aa, input logic [W-1:0] bb, input int lat,
                    input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez, input bit push);
    @(negedge clk);
    a = aa;
    b = bb;
    start_flag = 1'b1;
    @(posedge clk);
    #1;
    start_flag = 1'b0;
    if (push) sbq.push_back('{eq, er, ez, cyc + lat});
    chk("busy_after_start", busy, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sbq.size() != 0 || busy); i++) @(negedge clk);
    #1;
    chk("drain_queue_empty", sbq.size(), 0);
    chk("drain_idle", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    go(16'd100, 16'd7, 18, 16'd14, 16'd2, 1'b0, 1'b1);
    drain();
    go(16'd5, 16'd0, 1, 16'hFFFF, 16'd5, 1'b1, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    chk("dbz_held", div_by_zero, 1);
    chk("quotient_held", quotient, 16'hFFFF);
    go(16'hFFFF, 16'd1, 18, 16'hFFFF, 16'd0, 1'b0, 1'b1);
    drain();
    go(16'h1234, 16'h1234, 18, 16'd1, 16'd0, 1'b0, 1'b1);
    drain();
    go(16'd7, 16'd9, 18, 16'd0, 16'd7, 1'b0, 1'b1);
    drain();
    go(16'd65535, 16'd256, 18, 16'd255, 16'd255, 1'b0, 1'b1);
    drain();
    go(16'd1000, 16'd3, 18, 16'd333, 16'd1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    a = 16'd9;
    b = 16'd9;
    start_flag = 1'b1;
    @(negedge clk);
    start_flag = 1'b0;
    drain();
    @(negedge clk);
    a = 16'd20;
    b = 16'd6;
    start_flag = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    sbq.push_back('{16'd3, 16'd2, 1'b0, k + 18});
    sbq.push_back('{16'd5, 16'd1, 1'b0, k + 38});
    a = 16'd21;
    b = 16'd4;
    repeat (20) @(posedge clk);
    #1;
    start_flag = 1'b0;
    drain();
    go(16'd1000, 16'd3, 18, 16'd0, 16'd0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midop_rst_busy", busy, 0);
    chk("midop_rst_done", done, 0);
    chk("midop_rst_quotient", quotient, 0);
    chk("midop_rst_remainder", remainder, 0);
    chk("midop_rst_dbz", div_by_zero, 0);
    go(16'd1000, 16'd3, 18, 16'd333, 16'd1, 1'b0, 1'b1);
    drain();
`ifdef DIVIDER_SIGNED_EN
    signed_op = 1'b1;
    go(16'hFFF9, 16'd2, 18, 16'hFFFD, 16'hFFFF, 1'b0, 1'b1);
    drain();
    go(16'h8000, 16'hFFFF, 18, 16'h8000, 16'd0, 1'b0, 1'b1);
    drain();
    go(16'd7, 16'hFFFE, 18, 16'hFFFD, 16'd1, 1'b0, 1'b1);
    drain();
    go(16'hFFF9, 16'd0, 1, 16'hFFFF, 16'hFFF9, 1'b1, 1'b1);
    drain();
    signed_op = 1'b0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, as the operand and result width in bits.
REQ-002 The block SHALL take parameter ITERS, default WIDTH, as the number of SHIFT iterations.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start_flag  input  1  request to begin a division; sampled only in IDLE.
REQ-006 a  input  WIDTH  dividend; latched when start is accepted.
REQ-007 b  input  WIDTH  divisor; latched when start is accepted.
REQ-008 quotient  output  WIDTH  result quotient; registered.
REQ-009 remainder  output  WIDTH  result remainder; registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse; quotient and remainder are valid while it is high.
REQ-012 div_by_zero  output  1  set alongside done when the latched b is 0; held until the next accepted start.

Function
REQ-013 The state machine SHALL use states IDLE, CHECK, SHIFT, FIXUP and DONE.
REQ-014 In IDLE, start_flag=1 at edge k SHALL latch a and b and move to CHECK; start_flag in any other state SHALL be ignored.
REQ-015 CHECK SHALL take one cycle and SHALL:
- b==0: go to DONE at edge k+1, with quotient = all-ones and remainder = latched a.
- otherwise: clear the partial remainder, load the dividend shift register and go to SHIFT.
REQ-016 Each SHIFT cycle SHALL perform one restoring step:
- shift {rem, dvd} left by 1;
- trial = rem - divisor, computed WIDTH+1 bits wide;
- if trial is non-negative: rem = trial and quotient LSB = 1; else quotient LSB = 0.
REQ-017 A down-counter loaded with ITERS SHALL be decremented in each SHIFT cycle; the block SHALL go to FIXUP on the edge where the counter reaches 0.
REQ-018 FIXUP SHALL take one cycle and apply any sign correction (REQ-026), then go to DONE.
REQ-019 For b!=0, done SHALL be high in the cycle after edge k+18 (WIDTH=16); in general, latency = ITERS+2 edges.
REQ-020 DONE SHALL last one cycle, then return to IDLE.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values until the next accepted start.
REQ-022 start_flag held high across DONE→IDLE SHALL start a new operation at the first IDLE edge; there is no back-to-back acceptance in DONE.

Reset
REQ-023 rst=1 at any edge, including mid-operation, SHALL force IDLE and abandon the operation.
REQ-024 rst=1 SHALL clear quotient, remainder, busy, done, div_by_zero and the counter to 0.
REQ-025 rst SHALL take priority over start_flag.

Configuration
REQ-026 With macro DIVIDER_SIGNED_EN defined, the block SHALL operate as follows:
- add input signed_op (1 bit), latched at start;
- when signed_op=1: CHECK takes operand magnitudes; FIXUP negates the quotient if the operand signs differ, and negates the remainder if a was negative;
- the remainder SHALL take the dividend's sign;
- most-negative ÷ -1 SHALL give quotient = most-negative and remainder = 0;
- b==0 SHALL give quotient = all-ones and remainder = a.
REQ-027 Without DIVIDER_SIGNED_EN, the signed_op port SHALL be absent and all operations SHALL be unsigned; FIXUP SHALL still take one cycle so that latency is identical.

Structure
REQ-028 The enum div_state_t and constants DIV_WIDTH and DIV_ITERS SHALL live in package divider_pkg.
REQ-029 The single restoring iteration SHALL be a combinational sub-module divider_step (inputs rem, dvd, divisor; outputs next rem, next dvd, quotient bit), instantiated once.

Verification
REQ-030 a=100, b=7, start at edge k → done after edge k+18; quotient=14, remainder=2, div_by_zero=0.
REQ-031 a=5, b=0 → done after edge k+1; quotient=0xFFFF, remainder=5, div_by_zero=1.
REQ-032 a=0xFFFF, b=1, then a=0x1234, b=0x1234 → quotient=0xFFFF/remainder=0; then quotient=1/remainder=0.
REQ-033 Start a=1000, b=3; pulse start_flag with a=9, b=9 at cycle 5 → the second request is ignored; quotient=333, remainder=1.
REQ-034 Start a=1000, b=3; assert rst at cycle 8 → next cycle: busy=0, done=0, outputs=0, state IDLE; a new start then completes correctly.
REQ-035 With DIVIDER_SIGNED_EN and signed_op=1:
- -7/2 → quotient=0xFFFD, remainder=0xFFFF;
- 0x8000/0xFFFF → quotient=0x8000, remainder=0.
